// File: rtl/csa_fault_sel_gen_p_if.sv
`default_nettype none
// ============================================================================
//  Module   : csa_fault_sel_gen_p_if
//  Purpose  : Session control, copy outputs and select-chain bundle for the
//             CSA fault mux-select generator.
//  Revision : 1.0 - initial release
// ============================================================================
interface csa_fault_sel_gen_p_if #(
    parameter int NCH = 4,
    parameter int W   = 6
);
    logic               start;
    logic               test;
    logic [NCH*W-1:0]   actual_output;
    logic [W-1:0]       desired_output;
    logic [NCH-1:0]     comp;
    logic [NCH-1:0]     fault_map;
    logic [NCH-2:0]     is;
    logic [NCH-1:0]     ss;
    logic               busy;
    logic               done;
    logic               multi_fault;

    modport master (
        output start, test, actual_output, desired_output,
        input  comp, fault_map, is, ss, busy, done, multi_fault
    );

    modport slave (
        input  start, test, actual_output, desired_output,
        output comp, fault_map, is, ss, busy, done, multi_fault
    );
endinterface
`default_nettype wire

// File: rtl/csa_fault_sel_gen_p.sv
`default_nettype none
// ============================================================================
//  Module   : csa_fault_sel_gen_p
//  Purpose  : Compares NCH redundant copies against a golden value over a
//             bounded session and drives the CSA is/ss reconfiguration chain.
//  Revision : 1.0 - initial release
// ============================================================================
module csa_fault_sel_gen_p #(
    parameter int NCH    = 4,
    parameter int W      = 6,
    parameter int THRESH = 1,
    parameter int CNTW   = 4,
    parameter int NVEC   = 8
) (
    input  logic                    clk,
    input  logic                    init,
    csa_fault_sel_gen_p_if.slave    bus
);

    localparam int              VCW        = $clog2(NVEC + 1);
    localparam logic [VCW-1:0]  C_VEC_LAST = VCW'(NVEC - 1);
    localparam logic [CNTW-1:0] C_THRESH   = CNTW'(THRESH);
    localparam logic [CNTW-1:0] C_CNT_MAX  = {CNTW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [VCW-1:0]             r_vec_cnt;
    logic [NCH-1:0][CNTW-1:0]   r_cnt;
    logic [NCH-1:0][CNTW-1:0]   w_cnt_nxt;
    logic [NCH-1:0]             r_fault_map;
    logic [NCH-1:0]             w_fault_nxt;
    logic                       r_multi_fault;
    logic                       w_multi_nxt;
    logic                       w_seen;
    logic [NCH-1:0]             w_comp;
    logic [NCH-1:0]             w_ss;
    logic                       w_accept;
    logic                       w_last;

    // Per-copy mismatch detect, independent of state and test
    generate
        for (genvar g = 0; g < NCH; g++) begin : g_comp
            assign w_comp[g] = |(bus.actual_output[g*W +: W] ^ bus.desired_output);
        end
    endgenerate

    assign w_accept = (r_state == ST_RUN) && bus.test;
    assign w_last   = w_accept && (r_vec_cnt == C_VEC_LAST);

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                bus.busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.done    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_vec_cnt <= '0;
        end else if ((r_state == ST_IDLE) && bus.start) begin
            r_vec_cnt <= '0;
        end else if (w_accept) begin
            r_vec_cnt <= r_vec_cnt + 1'b1;
        end
    end

    // Saturating history counters; fault flags track the post-edge count
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_fault_nxt = r_fault_map;
        w_multi_nxt = 1'b0;
        w_seen      = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (w_accept && w_comp[i] && (r_cnt[i] != C_CNT_MAX)) begin
                w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
            if (w_cnt_nxt[i] >= C_THRESH) begin
                w_fault_nxt[i] = 1'b1;
            end
            if (w_fault_nxt[i]) begin
                if (w_seen) begin
                    w_multi_nxt = 1'b1;
                end
                w_seen = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_cnt         <= '0;
            r_fault_map   <= '0;
            r_multi_fault <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_fault_map   <= w_fault_nxt;
            r_multi_fault <= w_multi_nxt;
        end
    end

    // Each select is the OR of all fault flags at or below its index
    generate
        for (genvar k = 0; k < NCH; k++) begin : g_sel
            assign w_ss[k] = |r_fault_map[k:0];
        end
    endgenerate

    assign bus.comp        = w_comp;
    assign bus.fault_map   = r_fault_map;
    assign bus.ss          = w_ss;
    assign bus.is          = w_ss[NCH-2:0];
    assign bus.multi_fault = r_multi_fault;

endmodule
`default_nettype wire
